// File: rtl/snake_screen_seq.sv
// Screen sequencer and score unit for the snake game: START/PLAY/PAUSE/END flow,
// frame selection for the LED matrix, and sequential BCD score / high score.
module snake_screen_seq #(
    parameter int                         GRID_W      = 16,
    parameter int                         GRID_H      = 16,
    parameter int                         LEN_W       = 8,
    parameter int                         SCORE_MULT  = 5,
    parameter logic [31:0]                START_CODE   = 32'h20DFEA15,
    parameter logic [31:0]                RESTART_CODE = 32'h20DF6A95,
    parameter logic [31:0]                PAUSE_CODE   = 32'h20DF22DD,
    parameter int                         END_HOLD    = 50_000_000,
    parameter int                         BLINK_CYC   = 12_500_000,
    parameter logic [GRID_H*GRID_W-1:0]   START_IMG   = '1,
    parameter logic [GRID_H*GRID_W-1:0]   END_IMG     = '0
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [31:0]                 cmd_word,
    input  logic                        cmd_valid,
    input  logic                        game_over,
    input  logic [LEN_W-1:0]            length,
    input  logic [GRID_H*GRID_W-1:0]    game_grid,
    output logic [GRID_H*GRID_W-1:0]    disp_grid,
    output logic                        game_run,
    output logic                        game_rst,
    output logic [1:0]                  screen,
    output logic [15:0]                 score_bcd,
    output logic [15:0]                 hiscore_bcd
);

    localparam int NPIX    = GRID_H * GRID_W;
    localparam int HOLD_W  = $clog2(END_HOLD + 1);
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);
    localparam int PROD_W  = LEN_W + 32;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_off;
    logic [NPIX-1:0]     freeze_q;
    logic [NPIX-1:0]     disp_q;
    logic                rst_pulse_q;
    logic [15:0]         hiscore_q;

    logic is_start, is_restart, is_pause;
    logic pause_entry, end_entry, play_entry;

    assign is_start    = cmd_valid && (cmd_word == START_CODE);
    assign is_restart  = cmd_valid && (cmd_word == RESTART_CODE);
    assign is_pause    = cmd_valid && (cmd_word == PAUSE_CODE);
    assign pause_entry = (state_q == S_PLAY)  && (state_d == S_PAUSE);
    assign end_entry   = (state_q != S_END)   && (state_d == S_END);
    assign play_entry  = (state_q == S_START) && (state_d == S_PLAY);

    // NOTE: every output is assigned before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START: if (is_start) state_d = S_PLAY;
            S_PLAY: begin
                if (game_over)     state_d = S_END;
                else if (is_pause) state_d = S_PAUSE;
            end
            S_PAUSE: if (is_pause) state_d = S_PLAY;
            S_END:   if (hold_cnt == '0 && is_restart) state_d = S_START;
            default: state_d = S_START;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_START;
            rst_pulse_q <= 1'b1;
            hold_cnt    <= '0;
            hiscore_q   <= '0;
        end else begin
            state_q     <= state_d;
            rst_pulse_q <= play_entry;
            if (end_entry)
                hold_cnt <= HOLD_W'(END_HOLD - 1);
            else if (state_q == S_END && hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
            // BCD digits compare correctly as plain unsigned words
            if (end_entry && score_bcd > hiscore_q)
                hiscore_q <= score_bcd;
        end
    end

    // NOTE: the freeze buffer is pure data, written before it is ever displayed, so it needs no reset.
    always_ff @(posedge CLOCK_50) begin
        if (pause_entry)
            freeze_q <= game_grid;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            disp_q    <= START_IMG;
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else begin
            if (pause_entry) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (state_q == S_PAUSE) begin
                if (blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
                    blink_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
            case (state_q)
                S_START: disp_q <= START_IMG;
                S_PLAY:  disp_q <= game_grid;
                S_PAUSE: disp_q <= blink_off ? '0 : freeze_q;
                default: disp_q <= END_IMG;
            endcase
        end
    end

    // Score: saturated binary product, converted by one shift-add-3 step per cycle.
    logic [PROD_W-1:0] prod;
    logic [13:0]       bin_sat;
    logic              conv_busy;
    logic [3:0]        shift_cnt;
    logic [13:0]       bin_work, bin_shift;
    logic [15:0]       bcd_work, bcd_adj, bcd_shift;
    logic [LEN_W-1:0]  last_len;
    logic [15:0]       score_q;

    assign prod    = {32'd0, length} * PROD_W'(SCORE_MULT);
    assign bin_sat = (prod > PROD_W'(9999)) ? 14'd9999 : prod[13:0];

    function automatic logic [15:0] add3(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd_work);
    assign {bcd_shift, bin_shift} = {bcd_adj, bin_work} << 1;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            conv_busy <= 1'b0;
            shift_cnt <= '0;
            bin_work  <= '0;
            bcd_work  <= '0;
            last_len  <= '0;
            score_q   <= '0;
        end else if (!conv_busy) begin
            if (length != last_len) begin
                last_len  <= length;
                bin_work  <= bin_sat;
                bcd_work  <= '0;
                shift_cnt <= '0;
                conv_busy <= 1'b1;
            end
        end else begin
            bin_work  <= bin_shift;
            bcd_work  <= bcd_shift;
            shift_cnt <= shift_cnt + 4'd1;
            if (shift_cnt == 4'd13) begin
                conv_busy <= 1'b0;
                score_q   <= bcd_shift;
            end
        end
    end

    assign disp_grid   = disp_q;
    assign game_run    = (state_q == S_PLAY);
    assign game_rst    = rst_pulse_q;
    assign screen      = state_q;
    assign score_bcd   = score_q;
    assign hiscore_bcd = hiscore_q;

endmodule
